// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types, defaults and width helpers for the program loader
//
// Contents:
//   state_t            controller states (IDLE, LOAD, SETTLE, RUN, DONE)
//   FILL_WORD_DEFAULT  word served when pc is outside the loaded program (RV32I NOP)
//   cnt_width()        bits needed to hold a counter value 0..max_val

package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] FILL_WORD_DEFAULT = 32'h0000_0013;

    // Width of a counter that must represent 0..max_val; never less than one
    // bit so that degenerate parameter values still elaborate.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - DATA_W x 2**ADDR_W instruction memory, synchronous write, asynchronous read
//
// Ports:
//   clk    in   rising-edge clock for the write port
//   we     in   write enable
//   waddr  in   ADDR_W write word address
//   wdata  in   DATA_W write data
//   raddr  in   ADDR_W read word address
//   rdata  out  DATA_W read data, combinational from raddr

module prog_mem
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Contents are deliberately not reset: a program survives a reset and
    // only a new load overwrites it.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero-latency read so the cpu sees the instruction in the same cycle it
    // presents pc.
    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - program loader and instruction server in front of the cpu core
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   load_start    in   pulse: abort any activity and begin a new load at word 0
//   ld_valid      in   load word valid
//   ld_ready      out  loader accepts a word (registered, high only in LOAD)
//   ld_data       in   DATA_W instruction word
//   ld_last       in   final word of the program
//   pc            in   ADDR_W word index from the cpu
//   ins_out       out  DATA_W instruction to the cpu (mem[pc] in RUN, else FILL_WORD)
//   cpu_set       out  cpu enable, high only in RUN
//   end_addr      out  ADDR_W index of the last loaded word
//   busy          out  high in LOAD, SETTLE and RUN
//   done          out  high in DONE
//   timeout       out  sticky: run ended by the watchdog
//   err_overflow  out  sticky: load truncated at the end of memory

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 8,
    parameter int                SETTLE_CYC  = 4,
    parameter int                MAX_RUN_CYC = 1024,
    parameter logic [DATA_W-1:0] FILL_WORD   = DATA_W'(FILL_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ins_out,
    output logic              cpu_set,
    output logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              err_overflow
);

    localparam int SET_W = cnt_width(SETTLE_CYC - 1);
    localparam int RUN_W = $clog2(MAX_RUN_CYC + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [SET_W-1:0]  SET_INIT  = SET_W'(SETTLE_CYC - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(MAX_RUN_CYC - 1);
    localparam logic [RUN_W-1:0]  RUN_SAT   = '1;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [SET_W-1:0]  set_cnt;
    logic [RUN_W-1:0]  run_cnt;

    logic              accept;
    logic              beat_final;
    logic [DATA_W-1:0] mem_rdata;

    // load_start has priority over a beat presented in the same cycle; the
    // beat is dropped rather than written into the program being discarded.
    assign accept = ld_valid && ld_ready && !load_start;

    // A beat landing on the top address closes the load even without ld_last,
    // so wptr can never wrap back over the start of the program.
    assign beat_final = ld_last || (wptr == LAST_ADDR);

    prog_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wptr),
        .wdata (ld_data),
        .raddr (pc),
        .rdata (mem_rdata)
    );

    assign ins_out = ((state == ST_RUN) && (pc <= end_addr)) ? mem_rdata : FILL_WORD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            wptr         <= '0;
            end_addr     <= '0;
            set_cnt      <= '0;
            run_cnt      <= '0;
            cpu_set      <= 1'b0;
            ld_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            err_overflow <= 1'b0;
        end else if (load_start) begin
            state        <= ST_LOAD;
            wptr         <= '0;
            timeout      <= 1'b0;
            err_overflow <= 1'b0;
            cpu_set      <= 1'b0;
            ld_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ld_ready <= 1'b0;
                end

                ST_LOAD: begin
                    if (accept) begin
                        if (beat_final) begin
                            end_addr <= wptr;
                            if (!ld_last) begin
                                err_overflow <= 1'b1;
                            end
                            ld_ready <= 1'b0;
                            set_cnt  <= SET_INIT;
                            state    <= ST_SETTLE;
                        end else begin
                            wptr <= wptr + 1'b1;
                        end
                    end
                end

                // The counter is loaded on the accepting edge and the move to
                // RUN happens on the edge that finds it at zero, so the cpu is
                // released on the SETTLE_CYC-th edge after the accepting one.
                ST_SETTLE: begin
                    if (set_cnt == '0) begin
                        run_cnt <= '0;
                        cpu_set <= 1'b1;
                        state   <= ST_RUN;
                    end else begin
                        set_cnt <= set_cnt - 1'b1;
                    end
                end

                // Running past the program wins over the watchdog when both
                // happen in the same cycle.
                ST_RUN: begin
                    if (run_cnt != RUN_SAT) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                    if (pc > end_addr) begin
                        cpu_set <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else if (run_cnt == RUN_LAST) begin
                        timeout <= 1'b1;
                        cpu_set <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done <= 1'b1;
                end

                default: begin
                    cpu_set  <= 1'b0;
                    ld_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader with a behavioural reference model

module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int          DW    = 32;
    localparam int          AW    = 3;
    localparam int          DEPTH = 8;
    localparam int          SC    = 4;
    localparam int          MR    = 16;
    localparam logic [31:0] FILL  = 32'h0000_0013;

    logic          clk;
    logic          rst;
    logic          load_start;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic [AW-1:0] pc;
    logic [DW-1:0] ins_out;
    logic          cpu_set;
    logic [AW-1:0] end_addr;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          err_overflow;

    prog_loader #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .SETTLE_CYC  (SC),
        .MAX_RUN_CYC (MR),
        .FILL_WORD   (FILL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .pc           (pc),
        .ins_out      (ins_out),
        .cpu_set      (cpu_set),
        .end_addr     (end_addr),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } beat_t;

    typedef struct {
        int end_a;
        bit to;
        bit ovf;
        int len;
    } run_t;

    beat_t       exp_beats[$];
    run_t        exp_runs[$];
    logic [31:0] ref_mem [DEPTH];
    int          ref_end = 0;
    int          pc_seq [MR];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Reference outcome of a run: the cpu presents pc_seq[k] in RUN cycle k;
    // the run ends on the first cycle whose pc lies past the program, or after
    // MR cycles by watchdog.
    task automatic model_run(input int e, output int len, output bit to);
        len = MR;
        to  = 1'b1;
        for (int k = 0; k < MR; k++) begin
            if ((pc_seq[k] % DEPTH) > e) begin
                len = k + 1;
                to  = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // cpu model: steps through pc_seq while enabled, parks on pc_seq[0] otherwise.
    initial begin
        int k;
        k  = 0;
        pc = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cpu_set) begin
                pc = AW'(pc_seq[k]);
                if (k < MR - 1) k++;
            end else begin
                k  = 0;
                pc = AW'(pc_seq[0]);
            end
        end
    end

    // Monitor: checks accepted beats, settle latency, served instructions and
    // end-of-run status against the queues filled by the stimulus.
    initial begin
        beat_t b;
        run_t  r;
        int    t_last;
        int    run_cnt;
        bit    prev_cs;
        bit    prev_done;
        t_last = 0;
        run_cnt = 0;
        prev_cs = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ld_valid && ld_ready && !load_start) begin
                    if (exp_beats.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        b = exp_beats.pop_front();
                        chk("beat_data", ld_data, b.data);
                        if (b.last) t_last = cyc + 1;
                    end
                end
                if (cpu_set) begin
                    if (!prev_cs) begin
                        chk("settle_edges", cyc - t_last + 1, SC + 1);
                        run_cnt = 0;
                    end
                    run_cnt++;
                    chk("ins_out_run", ins_out, (int'(pc) <= ref_end) ? ref_mem[pc] : FILL);
                end else begin
                    chk("ins_out_idle", ins_out, FILL);
                end
                if (done && !prev_done) begin
                    if (exp_runs.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        r = exp_runs.pop_front();
                        chk("end_addr", end_addr, r.end_a);
                        chk("timeout", timeout, r.to);
                        chk("err_overflow", err_overflow, r.ovf);
                        chk("run_len", run_cnt, r.len);
                        chk("busy_done", busy, 0);
                        chk("cpu_set_done", cpu_set, 0);
                    end
                end
                prev_cs = cpu_set;
                prev_done = done;
            end else begin
                prev_cs = 1'b0;
                prev_done = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] w, input bit last, input int gap);
        int waited;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        ld_valid = 1'b1;
        ld_data  = w;
        ld_last  = last;
        waited   = 0;
        @(negedge clk);
        while (!ld_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!ld_ready) fail_now("beat_accept_wait");
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // mode 0: pc counts up from 0, mode 1: pc held at 0, mode 2: random pc.
    task automatic load_program(input int n, input bit has_last, input int mode,
                                input bit bp, input bit push_run);
        logic [31:0] w [12];
        int acc;
        int len;
        bit to;
        acc = has_last ? n : DEPTH;
        for (int k = 0; k < MR; k++) begin
            pc_seq[k] = (mode == 0) ? k : (mode == 1) ? 0 : int'($urandom_range(0, DEPTH - 1));
        end
        for (int i = 0; i < n; i++) w[i] = $urandom;
        for (int i = 0; i < acc; i++) begin
            ref_mem[i] = w[i];
            exp_beats.push_back('{data: w[i], last: (i == acc - 1)});
        end
        ref_end = acc - 1;
        model_run(ref_end, len, to);
        if (push_run) exp_runs.push_back('{end_a: acc - 1, to: to, ovf: !has_last, len: len});
        pulse_start();
        for (int i = 0; i < acc; i++) begin
            send_beat(w[i], has_last && (i == n - 1),
                      bp ? ((i == 0) ? 0 : 2) : int'($urandom_range(0, 2)));
        end
        if (n > acc) begin
            @(negedge clk);
            chk("ready_after_overflow", ld_ready, 0);
            chk("overflow_flag", err_overflow, 1);
            for (int i = acc; i < n; i++) begin
                ld_valid = 1'b1;
                ld_data  = w[i];
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
            end
            ld_valid = 1'b0;
        end
    endtask

    task automatic wait_flag(input bit want_done, input string name);
        int n;
        n = 0;
        while ((want_done ? !done : !cpu_set) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (want_done ? !done : !cpu_set) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        bit ovf;
        rst        = 1'b0;
        load_start = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        ld_last    = 1'b0;
        for (int k = 0; k < MR; k++) pc_seq[k] = 0;
        repeat (3) @(negedge clk);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cpu_set", cpu_set, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err_overflow", err_overflow, 0);
        chk("rst_end_addr", end_addr, 0);
        chk("rst_ins_out", ins_out, FILL);
        @(posedge clk);
        #1 rst = 1'b1;

        // basic run, backpressure, overflow (end at top: watchdog only), watchdog
        load_program(4, 1'b1, 0, 1'b0, 1'b1);
        wait_flag(1'b1, "basic_done");
        load_program(6, 1'b1, 0, 1'b1, 1'b1);
        wait_flag(1'b1, "bp_done");
        load_program(10, 1'b0, 0, 1'b0, 1'b1);
        wait_flag(1'b1, "ovf_done");
        load_program(3, 1'b1, 1, 1'b0, 1'b1);
        wait_flag(1'b1, "wd_done");

        // restart while running an overflowed program
        load_program(10, 1'b0, 1, 1'b0, 1'b0);
        wait_flag(1'b0, "restart_run");
        repeat (2) @(posedge clk);
        #1 load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
        @(negedge clk);
        chk("restart_cpu_set", cpu_set, 0);
        chk("restart_busy", busy, 1);
        chk("restart_ld_ready", ld_ready, 1);
        chk("restart_err_overflow", err_overflow, 0);
        chk("restart_timeout", timeout, 0);
        load_program(2, 1'b1, 0, 1'b0, 1'b1);
        wait_flag(1'b1, "restart_done");

        // asynchronous reset during LOAD
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] v;
            v = $urandom;
            exp_beats.push_back('{data: v, last: 1'b0});
            send_beat(v, 1'b0, 0);
        end
        #3 rst = 1'b0;
        #1;
        chk("arst_load_ld_ready", ld_ready, 0);
        chk("arst_load_busy", busy, 0);
        chk("arst_load_cpu_set", cpu_set, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        ld_valid = 1'b1;
        ld_data  = $urandom;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ld_ready", ld_ready, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end
        @(posedge clk);
        #1 ld_valid = 1'b0;

        // asynchronous reset during RUN drops cpu_set at once
        load_program(3, 1'b1, 1, 1'b0, 1'b0);
        wait_flag(1'b0, "arst_run");
        #3 rst = 1'b0;
        #1;
        chk("arst_run_cpu_set", cpu_set, 0);
        chk("arst_run_ins_out", ins_out, FILL);
        @(posedge clk);
        #1 rst = 1'b1;

        // randomized programs
        for (int it = 0; it < 20; it++) begin
            ovf = ($urandom_range(0, 3) == 0);
            load_program(ovf ? int'($urandom_range(8, 11)) : int'($urandom_range(1, 8)),
                         !ovf, int'($urandom_range(0, 2)), 1'b0, 1'b1);
            wait_flag(1'b1, "rand_done");
        end

        repeat (2) @(negedge clk);
        chk("beats_left", exp_beats.size(), 0);
        chk("runs_left", exp_runs.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Synthesizable program loader and instruction server for the cpu core; it replaces bench-side instruction feeding.
- Accepts a stream of instruction words over a valid/ready load port into internal word memory and holds the cpu inactive while settling.
- It then releases the cpu via cpu_set and serves ins_out from pc until pc passes the last loaded word or a watchdog expires.
- Sits between host/debug stream and the cpu ins_in/pc/cpu_set pins.

Parameters:
- DATA_W, 32, instruction word width.
- ADDR_W, 8, pc/word-address width; memory depth is 2**ADDR_W words.
- SETTLE_CYC, 4, cycles cpu_set is held low between load completion and run start (min 1).
- MAX_RUN_CYC, 1024, watchdog limit on RUN cycles (min 1).
- FILL_WORD, 32'h00000013, word driven on ins_out when pc is outside the loaded range (RV32I NOP).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  pulse; aborts any activity and starts a new load at address 0.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  loader accepts a word.
- ld_data  in  DATA_W  instruction word.
- ld_last  in  1  marks final word of program.
- pc  in  ADDR_W  word index from cpu.
- ins_out  out  DATA_W  instruction to cpu ins_in.
- cpu_set  out  1  cpu enable.
- end_addr  out  ADDR_W  index of last loaded word.
- busy  out  1  high in LOAD, SETTLE, RUN.
- done  out  1  high in DONE.
- timeout  out  1  sticky: run ended by watchdog.
- err_overflow  out  1  sticky: load truncated at memory end.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; write pointer wptr=0; end_addr=0.
  - cpu_set=0, ld_ready=0, busy=0, done=0, timeout=0, err_overflow=0.
  - Memory contents not reset.
- States: IDLE, LOAD, SETTLE, RUN, DONE. load_start in any state → LOAD next cycle; wptr, timeout and err_overflow clear; cpu_set=0.
- IDLE: ld_ready=0; waits for load_start.
- LOAD: ld_ready=1. Each cycle with ld_valid&&ld_ready: mem[wptr]<=ld_data, wptr<=wptr+1.
  - Accepted beat with ld_last=1: end_addr<=wptr; go to SETTLE.
  - Accepted beat at wptr==2**ADDR_W-1 with ld_last=0: treated as last; end_addr<=wptr; err_overflow<=1; go to SETTLE.
  - ld_valid=0 stalls indefinitely; no beat is lost.
  - load_start together with ld_valid: load_start wins and the beat is dropped.
- SETTLE:
  - Down-counter loaded with SETTLE_CYC-1 on entry; cpu_set=0, ld_ready=0.
  - Goes to RUN on the cycle after the counter reads 0. The delay from the last accepted beat to cpu_set=1 is exactly SETTLE_CYC+1 edges.
- RUN:
  - cpu_set=1.
  - ins_out = mem[pc] combinationally (zero latency, asynchronous read) when pc<=end_addr; otherwise FILL_WORD. ins_out=FILL_WORD in all other states.
  - Run counter starts at 0 on entry and increments each cycle.
  - Sampled pc>end_addr → DONE.
  - Otherwise, run counter == MAX_RUN_CYC-1 → DONE with timeout<=1.
  - If both occur in the same cycle, normal completion wins (timeout stays 0).
  - If end_addr=2**ADDR_W-1, only the watchdog ends the run.
- DONE: cpu_set=0, done=1; holds until load_start or reset. end_addr and the memory are retained.
- Width rules:
  - wptr is ADDR_W bits; it never wraps because overflow forces the end of the load.
  - Run counter is $clog2(MAX_RUN_CYC+1) bits, saturating.
  - Comparisons are unsigned.
- Reset mid-operation returns to IDLE immediately; cpu_set drops asynchronously.

Decomposition:
- Package prog_loader_pkg:
  - State enum (IDLE, LOAD, SETTLE, RUN, DONE).
  - FILL_WORD default.
  - Helper function computing counter widths.
- One sub-module: prog_mem, a parametrised DATA_W×2**ADDR_W memory with synchronous write and asynchronous read.
- FSM and counters stay in prog_loader.

Test Plan:
- Basic run:
  - Stimulus: load_start; 4 beats A0..A3 with ld_last on A3; cpu model increments pc each cycle from 0.
  - Response: end_addr=3; cpu_set rises SETTLE_CYC+1 edges after the A3 beat; ins_out=A0,A1,A2,A3; then FILL_WORD at pc=4, done=1, cpu_set=0, timeout=0.
- Backpressure:
  - Stimulus: ld_valid toggled 1,0,0,1,… over 6 words.
  - Response: mem[0..5] match in order, no duplicates or drops, end_addr=5.
- Overflow:
  - Stimulus: ADDR_W=3; 10 beats with no ld_last.
  - Response: the first 8 words are stored and ld_ready drops after the 8th; err_overflow=1; end_addr=7; beats 9–10 are not accepted.
- Watchdog:
  - Stimulus: MAX_RUN_CYC=16; pc held at 0.
  - Response: done after 16 RUN cycles, timeout=1; ins_out=mem[0] throughout RUN.
- Restart:
  - Stimulus: load_start asserted mid-RUN.
  - Response: cpu_set=0 the next cycle, LOAD entered, timeout and err_overflow cleared; a new 2-word program gives end_addr=1.
- Async reset:
  - Stimulus: rst=0 between clock edges during LOAD.
  - Response: ld_ready, busy and cpu_set go to 0 immediately; after release, state is IDLE and load_start is required.
